division: RTL and testbench

DIVISION -- requirements
Module: division

---
 rtl/division.sv | 104 ++++++++++
 tb/tb_division.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/division.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit per
// clock, MSB first. A division starts on the first rising clk edge after the
// active-low reset is released and finishes NW+1 edges later; the result is
// then held until the next reset.
// Optional feature: define DIVISION_REM_PORT_EN to add the remainder output r.
module division #(
  parameter int NW = 32,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NW-1:0] n,
  input  logic [DW-1:0] d,
  output logic [NW-1:0] q,
  output logic          isFactor,
  output logic          isDone
`ifdef DIVISION_REM_PORT_EN
  ,
  output logic [DW-1:0] r
`endif
);

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(NW) + 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  logic [1:0]    state_reg;
  // Holds the dividend; quotient bits shift in at the bottom as dividend bits
  // leave at the top, so after NW steps it holds the whole quotient.
  logic [NW-1:0] work_reg;
  logic [DW-1:0] d_reg;
  logic [DW:0]   rem_reg;
  logic [CW-1:0] cnt_reg;

  logic [DW:0]   rem_shift;
  logic [DW:0]   rem_next;
  logic          qbit;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = (rem_reg << 1) | {{DW{1'b0}}, work_reg[NW-1]};
    qbit      = (rem_shift >= {1'b0, d_reg});
    rem_next  = qbit ? (rem_shift - {1'b0, d_reg}) : rem_shift;
  end

  // Control FSM and datapath registers; outputs only change when entering DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= LOAD;
      work_reg  <= '0;
      d_reg     <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      q         <= '0;
      isFactor  <= 1'b0;
      isDone    <= 1'b0;
`ifdef DIVISION_REM_PORT_EN
      r         <= '0;
`endif
    end else begin
      case (state_reg)
        LOAD: begin
          work_reg <= n;
          d_reg    <= d;
          rem_reg  <= '0;
          cnt_reg  <= '0;
          if (d == '0) begin
            // Division by zero: saturate the quotient, no iterations needed.
            q         <= '1;
            isFactor  <= 1'b0;
            isDone    <= 1'b1;
            state_reg <= DONE;
          end else begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          work_reg <= {work_reg[NW-2:0], qbit};
          rem_reg  <= rem_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            q         <= {work_reg[NW-2:0], qbit};
            isFactor  <= (rem_next == '0);
            isDone    <= 1'b1;
`ifdef DIVISION_REM_PORT_EN
            r         <= rem_next[DW-1:0];
`endif
            state_reg <= DONE;
          end
        end
        DONE: begin
          // Terminal: results stay put until reset is asserted again.
        end
        default: begin
          state_reg <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_division.sv
// Scoreboard bench for division: each directed vector pushes its expected
// result; a monitor pops and compares on every rising edge of isDone.
module tb_division;

  logic        clk;
  logic        reset;
  logic [31:0] n;
  logic [15:0] d;
  logic [31:0] q;
  logic        isFactor;
  logic        isDone;
`ifdef DIVISION_REM_PORT_EN
  logic [15:0] r;
`endif

  division #(.NW(32), .DW(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .n        (n),
    .d        (d),
    .q        (q),
    .isFactor (isFactor),
    .isDone   (isDone)
`ifdef DIVISION_REM_PORT_EN
    ,
    .r        (r)
`endif
  );

  typedef struct {
    logic [31:0] q;
    logic        f;
    logic [15:0] r;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  int   done_count = 0;
  bit   done_prev = 0;
  bit   leak = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Rising edges seen since reset release.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) edge_cnt = 0;
      else edge_cnt++;
    end
  end

  // Monitor: compare against the scoreboard whenever isDone rises.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        done_prev = 0;
        leak = 0;
      end else begin
        if (!isDone && (q != 0 || isFactor)) leak = 1;
        if (isDone && !done_prev) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got q=%0h with no expectation queued", q);
          end else begin
            e = sb.pop_front();
            check("q", q, e.q);
            check("isFactor", {31'b0, isFactor}, {31'b0, e.f});
            check("latency", edge_cnt, e.lat);
            check("no_partial", {31'b0, leak}, 32'd0);
`ifdef DIVISION_REM_PORT_EN
            check("r", {16'b0, r}, {16'b0, e.r});
`endif
            $display("[TB] done: q=%0h isFactor=%0b edges=%0d", q, isFactor, edge_cnt);
          end
          done_count++;
        end
        done_prev = isDone;
      end
    end
  end

  task automatic run_vec(input logic [31:0] nv, input logic [15:0] dv,
                         input logic [31:0] qe, input logic fe, input logic [15:0] re,
                         input int lat, input bit disturb);
    int start;
    reset = 1'b0;
    @(negedge clk);
    n = nv;
    d = dv;
    sb.push_back('{qe, fe, re, lat});
    start = done_count;
    @(negedge clk);
    reset = 1'b1;
    if (disturb) begin
      repeat (6) @(posedge clk);
      #1;
      n = 32'hFFFF_0000;
      d = 16'h0003;
    end
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      if (done_count != start) break;
    end
    if (done_count == start) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no isDone for n=%0h d=%0h expected within 80 cycles", nv, dv);
      sb.delete();
    end
    // Results must hold in DONE regardless of input changes.
    n = ~nv;
    d = dv + 16'd1;
    repeat (3) @(negedge clk);
    #1;
    check("hold_q", q, qe);
    check("hold_isFactor", {31'b0, isFactor}, {31'b0, fe});
    check("hold_isDone", {31'b0, isDone}, 32'd1);
    // Asynchronous reset clears outputs without waiting for a clock edge.
    reset = 1'b0;
    #1;
    check("rst_q", q, 32'd0);
    check("rst_isDone", {31'b0, isDone}, 32'd0);
    check("rst_isFactor", {31'b0, isFactor}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    n = '0;
    d = '0;
    #1;
    check("init_q", q, 32'd0);
    check("init_isDone", {31'b0, isDone}, 32'd0);
    check("init_isFactor", {31'b0, isFactor}, 32'd0);

    run_vec(32'd100,        16'd11,     32'd9,          1'b0, 16'd1, 33, 1'b0);
    run_vec(32'd100,        16'd10,     32'd10,         1'b1, 16'd0, 33, 1'b0);
    run_vec(32'd27,         16'd3,      32'd9,          1'b1, 16'd0, 33, 1'b0);
    run_vec(32'd84,         16'd40,     32'd2,          1'b0, 16'd4, 33, 1'b0);
    run_vec(32'd5,          16'd0,      32'hFFFF_FFFF,  1'b0, 16'd0, 1,  1'b0);
    run_vec(32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  1'b1, 16'd0, 33, 1'b0);
    run_vec(32'd0,          16'd7,      32'd0,          1'b1, 16'd0, 33, 1'b0);
    run_vec(32'd5,          16'd9,      32'd0,          1'b0, 16'd5, 33, 1'b0);
    run_vec(32'd458745,     16'd7,      32'd65535,      1'b1, 16'd0, 33, 1'b0);
    run_vec(32'd100,        16'd7,      32'd14,         1'b0, 16'd2, 33, 1'b1);

    // Abort mid-RUN, then a fresh division must complete normally.
    reset = 1'b0;
    @(negedge clk);
    n = 32'd84;
    d = 16'd40;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_isDone", {31'b0, isDone}, 32'd0);
    check("abort_q", q, 32'd0);
    run_vec(32'd84,         16'd40,     32'd2,          1'b0, 16'd4, 33, 1'b0);

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
